div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 29 ++
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: func3 codes, FSM states
// and small decode helpers used by the divider and its integration logic.
package div_unit_pkg;

  localparam logic [2:0] FUNC3_DIV  = 3'b100;
  localparam logic [2:0] FUNC3_DIVU = 3'b101;
  localparam logic [2:0] FUNC3_REM  = 3'b110;
  localparam logic [2:0] FUNC3_REMU = 3'b111;

  localparam logic [3:0] FB_DIV    = 4'd4;
  localparam logic [5:0] ITER_LAST = 6'd31;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_PREP = 2'd1,
    DIV_CALC = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // Unlisted func3 codes fall through to DIVU: unsigned, quotient.
  function automatic logic is_signed_op(input logic [2:0] f);
    return (f == FUNC3_DIV) || (f == FUNC3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f);
    return (f == FUNC3_REM) || (f == FUNC3_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU; stalls the
// pipeline through div_busy and returns a single-cycle div_valid pulse.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        div_start,
  input  logic [2:0]  div_func3,
  input  logic [31:0] div_op_a,
  input  logic [31:0] div_op_b,
  input  logic        div_flush,
  output logic        div_busy,
  output logic        div_valid,
  output logic [31:0] div_result
);

  div_state_t  state;
  logic [2:0]  func3_q;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] divisor, quo, rem;
  logic [5:0]  counter;
  logic        q_neg, r_neg;

  logic        signed_op, rem_op, a_neg, b_neg, overflow;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted;
  logic        trial_ok;
  logic [31:0] step_rem, step_quo;
  logic [31:0] fixed_quo, fixed_rem;

  // The trial difference always fits in 32 bits once shifted >= divisor,
  // so the compare carries the 33rd bit and the subtract can stay narrow.
  always_comb begin
    signed_op = is_signed_op(func3_q);
    rem_op    = is_rem_op(func3_q);
    a_neg     = signed_op & op_a_q[31];
    b_neg     = signed_op & op_b_q[31];
    abs_a     = a_neg ? -op_a_q : op_a_q;
    abs_b     = b_neg ? -op_b_q : op_b_q;
    overflow  = signed_op && (op_a_q == 32'h8000_0000) && (op_b_q == 32'hFFFF_FFFF);
    shifted   = {rem, quo[31]};
    trial_ok  = shifted >= {1'b0, divisor};
    step_rem  = trial_ok ? (shifted[31:0] - divisor) : shifted[31:0];
    step_quo  = {quo[30:0], trial_ok};
    fixed_quo = q_neg ? -quo : quo;
    fixed_rem = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= DIV_IDLE;
      func3_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      divisor    <= '0;
      quo        <= '0;
      rem        <= '0;
      counter    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_busy   <= 1'b0;
      div_valid  <= 1'b0;
      div_result <= '0;
    end else begin
      div_valid <= 1'b0;
      if (div_flush) begin
        state    <= DIV_IDLE;
        div_busy <= 1'b0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (div_start) begin
              func3_q  <= div_func3;
              op_a_q   <= div_op_a;
              op_b_q   <= div_op_b;
              div_busy <= 1'b1;
              state    <= DIV_PREP;
            end
          end
          // Special cases store final values with signs cleared so DONE
          // passes them through untouched.
          DIV_PREP: begin
            if (op_b_q == 32'd0) begin
              quo     <= 32'hFFFF_FFFF;
              rem     <= op_a_q;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
              counter <= '0;
              state   <= DIV_DONE;
            end else if (overflow) begin
              quo     <= 32'h8000_0000;
              rem     <= '0;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
              counter <= '0;
              state   <= DIV_DONE;
            end else begin
              quo     <= abs_a;
              rem     <= '0;
              divisor <= abs_b;
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              counter <= ITER_LAST;
              state   <= DIV_CALC;
            end
          end
          DIV_CALC: begin
            rem <= step_rem;
            quo <= step_quo;
            if (counter == 6'd0) begin
              state <= DIV_DONE;
            end else begin
              counter <= counter - 6'd1;
            end
          end
          DIV_DONE: begin
            div_result <= rem_op ? fixed_rem : fixed_quo;
            div_valid  <= 1'b1;
            div_busy   <= 1'b0;
            state      <= DIV_IDLE;
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results from an
// arithmetic reference model, and a monitor checks them on every div_valid.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        div_start = 1'b0;
  logic [2:0]  div_func3 = 3'd0;
  logic [31:0] div_op_a = 32'd0;
  logic [31:0] div_op_b = 32'd0;
  logic        div_flush = 1'b0;
  logic        div_busy;
  logic        div_valid;
  logic [31:0] div_result;

  typedef struct {
    logic [31:0] result;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  logic [31:0] last_result = 32'd0;

  logic [2:0]  dir_f [11] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [31:0] dir_a [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'hFFFF_FFFF};
  logic [31:0] dir_b [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd10};

  div_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .div_start  (div_start),
    .div_func3  (div_func3),
    .div_op_a   (div_op_a),
    .div_op_b   (div_op_b),
    .div_flush  (div_flush),
    .div_busy   (div_busy),
    .div_valid  (div_valid),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic bit ref_signed(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b110);
  endfunction

  function automatic bit ref_rem(input logic [2:0] f);
    return (f == 3'b110) || (f == 3'b111);
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (ref_signed(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Plain language-level division: SV truncates toward zero and gives the
  // remainder the dividend's sign, matching the RISC-V definition.
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int sr;
    if (b == 32'd0) return ref_rem(f) ? a : 32'hFFFF_FFFF;
    if (ref_signed(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return ref_rem(f) ? 32'd0 : 32'h8000_0000;
    if (ref_signed(f)) begin
      sa = a;
      sb = b;
      sr = ref_rem(f) ? (sa % sb) : (sa / sb);
      return 32'(sr);
    end
    return ref_rem(f) ? (a % b) : (a / b);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input bit expect_result, output int t0);
    exp_t e;
    div_func3 = f;
    div_op_a  = a;
    div_op_b  = b;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    t0 = cycle;
    if (expect_result) begin
      e.result = ref_div(f, a, b);
      e.due    = t0 + (ref_special(f, a, b) ? 2 : 34);
      exp_q.push_back(e);
      last_result = e.result;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check_output({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int t0;
    apply_stimulus(f, a, b, 1'b1, t0);
    check_output("busy_after_start", {31'd0, div_busy}, 32'd1);
    wait_drain("op");
  endtask

  always @(negedge clk) begin
    if (div_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid actual=0x%08h expected=no valid", div_result);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("result", div_result, mon_e.result);
        check_output("latency", 32'(cycle), 32'(mon_e.due));
      end
    end
  end

  initial begin
    int t0;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", {31'd0, div_busy}, 32'd0);
    check_output("reset_valid", {31'd0, div_valid}, 32'd0);
    check_output("reset_result", div_result, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_op(dir_f[i], dir_a[i], dir_b[i]);

    // Back-to-back: the second start lands on the cycle div_valid is high.
    apply_stimulus(3'd4, 32'd1000, 32'd3, 1'b1, t0);
    wait_drain("b2b_first");
    apply_stimulus(3'd6, 32'd1000, 32'd3, 1'b1, t0);
    check_output("b2b_accept_busy", {31'd0, div_busy}, 32'd1);
    wait_drain("b2b_second");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb);
    end

    apply_stimulus(3'd4, 32'd1234567, 32'd89, 1'b1, t0);
    do @(negedge clk); while (cycle < t0 + 4);
    div_func3 = 3'd6;
    div_op_a  = 32'd55;
    div_op_b  = 32'd4;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    wait_drain("ignored_start");

    apply_stimulus(3'd4, 32'd999999, 32'd13, 1'b0, t0);
    do @(negedge clk); while (cycle < t0 + 9);
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    @(negedge clk);
    check_output("flush_busy", {31'd0, div_busy}, 32'd0);
    repeat (40) @(negedge clk);
    check_output("flush_result_held", div_result, last_result);

    div_func3 = 3'd5;
    div_op_a  = 32'd77;
    div_op_b  = 32'd7;
    div_start = 1'b1;
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    div_flush = 1'b0;
    check_output("flush_over_start_busy", {31'd0, div_busy}, 32'd0);
    repeat (40) @(negedge clk);
    check_output("flush_over_start_result", div_result, last_result);

    apply_stimulus(3'd7, 32'd424242, 32'd17, 1'b0, t0);
    do @(negedge clk); while (cycle < t0 + 19);
    #2 rstn = 1'b0;
    #1;
    check_output("midreset_busy", {31'd0, div_busy}, 32'd0);
    check_output("midreset_valid", {31'd0, div_valid}, 32'd0);
    check_output("midreset_result", div_result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    last_result = 32'd0;
    repeat (40) @(negedge clk);
    check_output("post_reset_busy", {31'd0, div_busy}, 32'd0);
    check_output("post_reset_result", div_result, 32'd0);

    run_op(3'd4, 32'd100, 32'd7);

    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
